// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-register occupancy encoding and bubble fill.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  // Every bit of a bubble payload takes this value unless a stage overrides it.
  localparam logic BUBBLE_FILL = 1'b0;

endpackage

// File: rtl/sat_cnt32.sv
// 32-bit saturating event counter with enable and synchronous clear (clear loads CLR_VAL).
module sat_cnt32 #(
  parameter logic [31:0] CLR_VAL = '0
) (
  input  logic        clk,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= CLR_VAL;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register with registered up_ready and flush.
// Optional stall/bubble performance counters under `define PIPE_SKID_PERF_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned         DATA_W     = 64,
  parameter logic [DATA_W-1:0]   BUBBLE_VAL = {DATA_W{BUBBLE_FILL}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  occ_e              state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              up_ready_q;
  logic              dn_valid_q;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = up_valid && up_ready_q;
  assign out_xfer = dn_valid_q && dn_ready;

  // main_q is forced to BUBBLE_VAL whenever the stage empties, so dn_data needs no mux.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q    <= ST_EMPTY;
      main_q     <= BUBBLE_VAL;
      skid_q     <= BUBBLE_VAL;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_q     <= up_data;
            dn_valid_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= up_data;
          end else if (in_xfer) begin
            skid_q     <= up_data;
            up_ready_q <= 1'b0;
            state_q    <= ST_FULL;
          end else if (out_xfer) begin
            main_q     <= BUBBLE_VAL;
            dn_valid_q <= 1'b0;
            state_q    <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_q     <= skid_q;
            skid_q     <= BUBBLE_VAL;
            up_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q    <= ST_EMPTY;
          main_q     <= BUBBLE_VAL;
          skid_q     <= BUBBLE_VAL;
          up_ready_q <= 1'b1;
          dn_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign up_ready = up_ready_q;
  assign dn_valid = dn_valid_q;
  assign dn_data  = main_q;

`ifdef PIPE_SKID_PERF_EN
  logic stall_en;
  logic bubble_en;

  assign stall_en  = dn_valid_q && !dn_ready;
  assign bubble_en = !dn_valid_q;

  sat_cnt32 u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (stall_en),
    .cnt_o (stall_cnt)
  );

  sat_cnt32 u_bubble_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (bubble_en),
    .cnt_o (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vector table, counter sequences,
// and randomized traffic against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int unsigned DW = 64;
  localparam logic [DW-1:0] BUBBLE = '0;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          up_valid;
  logic          up_ready;
  logic [DW-1:0] up_data;
  logic          dn_valid;
  logic          dn_ready;
  logic [DW-1:0] dn_data;
`ifdef PIPE_SKID_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
`endif

  logic          sc_clr;
  logic          sc_en;
  logic [31:0]   sc_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_skid_reg #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .up_data  (up_data),
    .dn_valid (dn_valid),
    .dn_ready (dn_ready),
    .dn_data  (dn_data)
`ifdef PIPE_SKID_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  sat_cnt32 #(.CLR_VAL(32'hFFFF_FFFD)) u_sat (
    .clk   (clk),
    .clr_i (sc_clr),
    .en_i  (sc_en),
    .cnt_o (sc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered queue of at most two held entries.
  logic [DW-1:0] mq[$];
  logic [31:0]   m_stall;
  logic [31:0]   m_bubble;

  function automatic logic m_ur();
    return mq.size() < 2;
  endfunction
  function automatic logic m_dv();
    return mq.size() > 0;
  endfunction
  function automatic logic [DW-1:0] m_dd();
    return (mq.size() > 0) ? mq[0] : BUBBLE;
  endfunction

  task automatic model_step();
    logic inx, outx;
    inx  = up_valid && (mq.size() < 2);
    outx = (mq.size() > 0) && dn_ready;
    if (rst) begin
      m_stall  = '0;
      m_bubble = '0;
    end else begin
      if ((mq.size() > 0) && !dn_ready && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
      if ((mq.size() == 0) && (m_bubble != 32'hFFFF_FFFF)) m_bubble = m_bubble + 1;
    end
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (outx) void'(mq.pop_front());
      if (inx) mq.push_back(up_data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic          flush;
    logic          uv;
    logic [DW-1:0] ud;
    logic          dr;
    logic          eur;
    logic          edv;
    logic [DW-1:0] edd;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic r, input logic f, input logic uv, input logic [DW-1:0] ud,
                      input logic dr, input logic eur, input logic edv, input logic [DW-1:0] edd);
    vec_t v;
    v.rst = r; v.flush = f; v.uv = uv; v.ud = ud; v.dr = dr;
    v.eur = eur; v.edv = edv; v.edd = edd;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
    sc_clr = 1'b0; sc_en = 1'b0;
    m_stall = '0; m_bubble = '0;

    // rst flush uv data dr | up_ready dn_valid dn_data (after the edge)
    addv(1, 0, 0, 0, 0, 1, 0, BUBBLE);
    for (int unsigned k = 1; k <= 8; k++) addv(0, 0, 1, DW'(k), 1, 1, 1, DW'(k));
    addv(0, 0, 0, 0, 1, 1, 0, BUBBLE);
    // backpressure: 5 accepted, 6 into skid, 7 held upstream
    addv(0, 0, 1, 5, 1, 1, 1, 5);
    addv(0, 0, 1, 6, 0, 0, 1, 5);
    addv(0, 0, 1, 7, 0, 0, 1, 5);
    addv(0, 0, 1, 7, 1, 1, 1, 6);
    addv(0, 0, 1, 7, 1, 1, 1, 7);
    addv(0, 0, 0, 0, 1, 1, 0, BUBBLE);
    // flush while FULL with 9 offered
    addv(0, 0, 1, 1, 0, 1, 1, 1);
    addv(0, 0, 1, 2, 0, 0, 1, 1);
    addv(0, 1, 1, 9, 1, 1, 0, BUBBLE);
    addv(0, 0, 0, 0, 1, 1, 0, BUBBLE);
    // reset in FULL together with flush, then immediate acceptance
    addv(0, 0, 1, 3, 0, 1, 1, 3);
    addv(0, 0, 1, 4, 0, 0, 1, 3);
    addv(1, 1, 1, 5, 1, 1, 0, BUBBLE);
    addv(0, 0, 1, 6, 0, 1, 1, 6);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; flush = vecs[i].flush; up_valid = vecs[i].uv;
      up_data = vecs[i].ud; dn_ready = vecs[i].dr;
      tick();
      chk($sformatf("vec%0d.up_ready", i), DW'(up_ready), DW'(vecs[i].eur));
      chk($sformatf("vec%0d.dn_valid", i), DW'(dn_valid), DW'(vecs[i].edv));
      chk($sformatf("vec%0d.dn_data", i), dn_data, vecs[i].edd);
`ifdef PIPE_SKID_PERF_EN
      if (vecs[i].rst) begin
        chk($sformatf("vec%0d.stall_cnt_rst", i), DW'(stall_cnt), '0);
        chk($sformatf("vec%0d.bubble_cnt_rst", i), DW'(bubble_cnt), '0);
      end
`endif
    end

`ifdef PIPE_SKID_PERF_EN
    // 3 stall cycles and 2 idle cycles after reset
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
    tick();
    rst = 1'b0; up_valid = 1'b1; up_data = 64'd11;
    tick();
    up_valid = 1'b0;
    tick(); tick(); tick();
    dn_ready = 1'b1;
    tick(); tick();
    chk("perf.stall_cnt", DW'(stall_cnt), DW'(32'd3));
    chk("perf.bubble_cnt", DW'(bubble_cnt), DW'(32'd2));
`endif

    // Saturation of a counter preloaded near its maximum
    sc_clr = 1'b1; sc_en = 1'b0;
    tick();
    chk("sat.preload", DW'(sc_cnt), DW'(32'hFFFF_FFFD));
    sc_clr = 1'b0;
    tick();
    chk("sat.hold_disabled", DW'(sc_cnt), DW'(32'hFFFF_FFFD));
    sc_en = 1'b1;
    tick();
    chk("sat.inc", DW'(sc_cnt), DW'(32'hFFFF_FFFE));
    tick(); tick(); tick();
    chk("sat.saturated", DW'(sc_cnt), DW'(32'hFFFF_FFFF));
    sc_en = 1'b0;

    // Randomized traffic against the reference model
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
    tick();
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 79) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      up_valid = ($urandom_range(0, 3) != 0);
      up_data  = {$urandom, $urandom};
      dn_ready = ($urandom_range(0, 2) != 0);
      tick();
      chk($sformatf("rnd%0d.up_ready", n), DW'(up_ready), DW'(m_ur()));
      chk($sformatf("rnd%0d.dn_valid", n), DW'(dn_valid), DW'(m_dv()));
      chk($sformatf("rnd%0d.dn_data", n), dn_data, m_dd());
`ifdef PIPE_SKID_PERF_EN
      chk($sformatf("rnd%0d.stall_cnt", n), DW'(stall_cnt), DW'(m_stall));
      chk($sformatf("rnd%0d.bubble_cnt", n), DW'(bubble_cnt), DW'(m_bubble));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width (pc+inst).
REQ-002 SHALL have parameter BUBBLE_VAL, default all-zero, dn_data value while no entry is valid.
REQ-003 SHALL have port clk  input  1  clock; all state rises on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all held entries.
REQ-006 SHALL have port up_valid  input  1  upstream offers up_data.
REQ-007 SHALL have port up_ready  output  1  block can accept.
REQ-008 SHALL have port up_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port dn_valid  output  1  dn_data holds a valid entry.
REQ-010 SHALL have port dn_ready  input  1  downstream consumes.
REQ-011 SHALL have port dn_data  output  DATA_W  downstream payload.
REQ-012 SHALL have ports stall_cnt and bubble_cnt  output  32 each  performance counters, present only per REQ-030.

Function
REQ-013 SHALL hold two entries, main (drives dn_data) and skid, with occupancy state EMPTY, ONE, FULL.
REQ-014 SHALL treat transfer in as up_valid&&up_ready and transfer out as dn_valid&&dn_ready, both sampled at posedge.
REQ-015 SHALL drive up_ready from a register: 1 in EMPTY/ONE, 0 in FULL, with no combinational path from dn_ready.
REQ-016 SHALL present data accepted at edge N on dn_data/dn_valid after edge N (one-cycle latency) when EMPTY.
REQ-017 SHALL sustain one transfer per cycle in ONE with simultaneous in and out (main reloads from up_data).
REQ-018 SHALL, on transfer in without transfer out while in ONE, store up_data in skid and go FULL.
REQ-019 SHALL, on transfer out in FULL, move skid to main and go ONE; up_ready returns to 1 the next cycle.
REQ-020 SHALL transition ONE->EMPTY on transfer out without transfer in; dn_data then equals BUBBLE_VAL.
REQ-021 SHALL deliver entries strictly in acceptance order, with none lost or duplicated.
REQ-022 SHALL hold dn_data and dn_valid stable while dn_valid=1 and dn_ready=0.
REQ-023 SHALL, on flush, go EMPTY next cycle with dn_valid=0, dn_data=BUBBLE_VAL, up_ready=1; flush overrides a simultaneous transfer in or out, and the flushed input is dropped.
REQ-024 SHALL drive dn_data=BUBBLE_VAL whenever dn_valid=0.

Reset
REQ-025 SHALL, on rst at posedge, force EMPTY, dn_valid=0, dn_data=BUBBLE_VAL, up_ready=1, counters=0.
REQ-026 SHALL give rst priority over flush and all transfers, discarding held entries mid-operation.
REQ-027 SHALL, in the first cycle after rst deasserts, accept input normally.

Configuration
REQ-028 SHALL use macro PIPE_SKID_PERF_EN.
REQ-029 SHALL, with the macro defined, increment stall_cnt each cycle dn_valid&&!dn_ready, and increment bubble_cnt each non-reset cycle dn_valid=0, both saturating at 32'hFFFFFFFF.
REQ-030 SHALL, with the macro undefined, omit both counter ports and logic, leaving datapath behaviour identical.

Structure
REQ-031 SHALL take the state encoding (EMPTY/ONE/FULL) and default bubble constant from shared package pipe_pkg.
REQ-032 SHALL implement counters in one sub-module sat_cnt32 (enable, sync clear, saturate), instantiated twice under the macro.

Verification
REQ-033 SHALL check streaming: dn_ready=1, up_valid=1 with data 1..8 on consecutive cycles -> dn_data 1..8 one cycle later each, up_ready constantly 1.
REQ-034 SHALL check backpressure: dn_ready=0 after data 5 is accepted, offer 6, 7 -> 6 held in skid, up_ready=0, 7 held upstream; release dn_ready -> 5, 6, 7 in order, no loss.
REQ-035 SHALL check flush in FULL with simultaneous up_valid carrying data 9 -> next cycle dn_valid=0, dn_data=BUBBLE_VAL, up_ready=1, 9 never appears.
REQ-036 SHALL check rst asserted in FULL together with flush -> EMPTY, outputs per REQ-025, counters 0.
REQ-037 SHALL check, with PIPE_SKID_PERF_EN, 3 stall cycles plus 2 idle cycles -> stall_cnt=3, bubble_cnt=2; a preloaded near-max counter saturates at 32'hFFFFFFFF.
